call_stack: RTL and testbench
=============================

// Module: call_stack
// PURPOSE
//   Parametrised hardware subroutine stack for the control unit. Stores the return
//   PC and the ALU flags on callSubrutine and restores them on ReturnSubrutine.
//   Generalises the fixed single-entry push/pop stack: depth, PC width and flag
//   width are configurable, and it adds occupancy, full/empty, sticky error flags
//   and defined behaviour for a combined push+pop.
// PARAMETERS
//   PC_WIDTH    9  width of stored return address
//   FLAG_WIDTH  4  width of stored ALU flags
//   DEPTH       8  number of entries, power of two, >=2
// PORTS
//   clk             in   1             system clock, rising edge
//   reset           in   1             synchronous, active-high reset
//   in_push_en      in   1             push {in_pc,in_flags} this cycle
//   in_pop_en       in   1             pop top entry this cycle
//   in_pc           in   PC_WIDTH      return address to push
//   in_flags        in   FLAG_WIDTH    ALU flags to push
//   in_clear_err    in   1             clear sticky error flags
//   out_pc          out  PC_WIDTH      PC of last successful pop (registered)
//   out_flags       out  FLAG_WIDTH    flags of last successful pop (registered)
//   out_pop_valid   out  1             one-cycle pulse: out_pc/out_flags just updated
//   out_depth       out  log2(DEPTH)+1 current occupancy, 0..DEPTH
//   out_empty       out  1             out_depth==0
//   out_full        out  1             out_depth==DEPTH
//   out_overflow    out  1             sticky: push attempted while full
//   out_underflow   out  1             sticky: pop attempted while empty
// BEHAVIOUR
//   - Reset: depth=0, out_pc=0, out_flags=0, out_pop_valid=0, both error flags=0;
//     storage contents undefined; reset overrides every other input that cycle.
//   - Storage: DEPTH x (PC_WIDTH+FLAG_WIDTH) register array; pointer sp = out_depth.
//   - Push only (not full): mem[sp]<={in_pc,in_flags}; depth+1 on the same edge.
//   - Pop only (not empty): {out_pc,out_flags}<=mem[sp-1]; depth-1; out_pop_valid=1
//     in the following cycle (latency 1 clock from pop_en sampled to valid data).
//   - Push+pop, not empty: out <= old top; mem[sp-1] <= new value; depth unchanged;
//     out_pop_valid=1 (tail-call / return-then-call).
//   - Push+pop, empty: treated as push only; underflow NOT set.
//   - Push while full (no pop): entry dropped, depth unchanged, out_overflow<=1.
//   - Pop while empty (no push): out_pc/out_flags hold, out_pop_valid=0,
//     out_underflow<=1.
//   - Error flags stay 1 until in_clear_err or reset; when in_clear_err and a new
//     error occur in the same cycle, the flag is set (set wins).
//   - out_empty/out_full/out_depth are registered state, never combinational from
//     inputs; out_pop_valid is 0 in every cycle without a successful pop.
//   - Reset mid-sequence discards all entries; next pop after reset underflows.
//   - No wrap-around: sp saturates at 0 and DEPTH, never rolls over.
// TESTING
//   1 reset; push (pc=0x1E1,fl=4'b1001), pop -> next cycle out_pc=0x1E1,
//     out_flags=1001, out_pop_valid=1 for exactly one cycle, out_empty=1.
//   2 push 0x001..0x008 (DEPTH=8) -> out_full=1, depth=8; 9th push 0x0FF ->
//     out_overflow=1, depth=8; 8 pops return 0x008..0x001 in LIFO order.
//   3 pop on empty -> out_underflow=1, out_pc unchanged, out_pop_valid=0;
//     in_clear_err -> out_underflow=0 next cycle.
//   4 push 0x010, push 0x020, then push 0x030+pop same cycle -> out_pc=0x020,
//     depth=2; next pop -> 0x030, next pop -> 0x010.
//   5 push 3 entries, assert reset for one cycle -> depth=0, out_empty=1,
//     out_pc=0; following pop -> out_underflow=1.
//   6 push+pop on empty with in_pc=0x055 -> depth=1, no underflow, no valid pulse;
//     pop -> out_pc=0x055.

Source files
------------

// File: rtl/call_stack_if.sv
// Subroutine stack bus: push/pop requests in,
// restored PC/flags and occupancy status out.
interface call_stack_if #(
    parameter int PC_WIDTH   = 9,
    parameter int FLAG_WIDTH = 4,
    parameter int DEPTH      = 8
);
    localparam int DW = $clog2(DEPTH) + 1;

    logic                  in_push_en;
    logic                  in_pop_en;
    logic [PC_WIDTH-1:0]   in_pc;
    logic [FLAG_WIDTH-1:0] in_flags;
    logic                  in_clear_err;
    logic [PC_WIDTH-1:0]   out_pc;
    logic [FLAG_WIDTH-1:0] out_flags;
    logic                  out_pop_valid;
    logic [DW-1:0]         out_depth;
    logic                  out_empty;
    logic                  out_full;
    logic                  out_overflow;
    logic                  out_underflow;

    modport master (
        output in_push_en, in_pop_en, in_pc,
        output in_flags, in_clear_err,
        input  out_pc, out_flags, out_pop_valid,
        input  out_depth, out_empty, out_full,
        input  out_overflow, out_underflow
    );

    modport slave (
        input  in_push_en, in_pop_en, in_pc,
        input  in_flags, in_clear_err,
        output out_pc, out_flags, out_pop_valid,
        output out_depth, out_empty, out_full,
        output out_overflow, out_underflow
    );
endinterface

// File: rtl/call_stack.sv
// Parametrised return-address/flags stack with
// occupancy, saturating pointer and sticky errors.
module call_stack #(
    parameter int PC_WIDTH   = 9,
    parameter int FLAG_WIDTH = 4,
    parameter int DEPTH      = 8
) (
    input  logic       clk,
    input  logic       reset,
    call_stack_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int DW = AW + 1;
    localparam int EW = PC_WIDTH + FLAG_WIDTH;

    logic [EW-1:0]         mem_q [DEPTH];
    logic [DW-1:0]         depth_q, depth_d;
    logic [PC_WIDTH-1:0]   pc_q, pc_d;
    logic [FLAG_WIDTH-1:0] fl_q, fl_d;
    logic                  valid_q, valid_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;

    logic          push, pop, clr;
    logic          empty, full;
    logic          do_pop, do_wr;
    logic [DW-1:0] top_w;
    logic [AW-1:0] top_idx, wr_idx;

    assign push = bus.in_push_en;
    assign pop  = bus.in_pop_en;
    assign clr  = bus.in_clear_err;

    always_comb begin
        empty   = (depth_q == '0);
        full    = (depth_q == DW'(DEPTH));
        top_w   = depth_q - DW'(1);
        top_idx = top_w[AW-1:0];
        do_pop  = pop && !empty;
        // combined push+pop on a live stack replaces the top in place
        do_wr   = push && (do_pop || !full);
        wr_idx  = do_pop ? top_idx : depth_q[AW-1:0];

        depth_d = depth_q;
        if (do_wr && !do_pop)
            depth_d = depth_q + DW'(1);
        else if (do_pop && !push)
            depth_d = depth_q - DW'(1);

        pc_d = pc_q;
        fl_d = fl_q;
        if (do_pop)
            {pc_d, fl_d} = mem_q[top_idx];

        valid_d = do_pop;
        ovf_d = (ovf_q && !clr) || (push && !pop && full);
        unf_d = (unf_q && !clr) || (pop && !push && empty);
    end

    always_ff @(posedge clk) begin
        if (!reset && do_wr)
            mem_q[wr_idx] <= {bus.in_pc, bus.in_flags};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            depth_q <= '0;
            pc_q    <= '0;
            fl_q    <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            depth_q <= depth_d;
            pc_q    <= pc_d;
            fl_q    <= fl_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign bus.out_pc        = pc_q;
    assign bus.out_flags     = fl_q;
    assign bus.out_pop_valid = valid_q;
    assign bus.out_depth     = depth_q;
    assign bus.out_empty     = empty;
    assign bus.out_full      = full;
    assign bus.out_overflow  = ovf_q;
    assign bus.out_underflow = unf_q;
endmodule

// File: tb/tb_call_stack.sv
// Random and directed stimulus for call_stack,
// checked every cycle against a queue-based model.
module tb_call_stack;
    localparam int PW = 9;
    localparam int FW = 4;
    localparam int D  = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    call_stack_if #(.PC_WIDTH(PW), .FLAG_WIDTH(FW), .DEPTH(D)) bus ();

    call_stack #(.PC_WIDTH(PW), .FLAG_WIDTH(FW), .DEPTH(D)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    logic [PW+FW-1:0] m_q[$];
    logic [PW-1:0]    m_pc;
    logic [FW-1:0]    m_fl;
    logic             m_valid, m_ovf, m_unf;

    task automatic check(input string nm,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // behavioural model: a LIFO queue plus last-pop registers
    always @(posedge clk) begin
        logic nov, nun;
        if (reset) begin
            m_q.delete();
            m_pc = '0; m_fl = '0;
            m_valid = 0; m_ovf = 0; m_unf = 0;
        end else begin
            nov = 0; nun = 0; m_valid = 0;
            if (bus.in_push_en && bus.in_pop_en) begin
                if (m_q.size() > 0) begin
                    {m_pc, m_fl} = m_q[$];
                    m_q[$] = {bus.in_pc, bus.in_flags};
                    m_valid = 1;
                end else
                    m_q.push_back({bus.in_pc, bus.in_flags});
            end else if (bus.in_push_en) begin
                if (m_q.size() < D)
                    m_q.push_back({bus.in_pc, bus.in_flags});
                else
                    nov = 1;
            end else if (bus.in_pop_en) begin
                if (m_q.size() > 0) begin
                    {m_pc, m_fl} = m_q.pop_back();
                    m_valid = 1;
                end else
                    nun = 1;
            end
            m_ovf = (m_ovf && !bus.in_clear_err) || nov;
            m_unf = (m_unf && !bus.in_clear_err) || nun;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("depth", 32'(bus.out_depth), 32'(m_q.size()));
            check("empty", 32'(bus.out_empty), 32'(m_q.size() == 0));
            check("full", 32'(bus.out_full), 32'(m_q.size() == D));
            check("pc", 32'(bus.out_pc), 32'(m_pc));
            check("flags", 32'(bus.out_flags), 32'(m_fl));
            check("valid", 32'(bus.out_pop_valid), 32'(m_valid));
            check("ovf", 32'(bus.out_overflow), 32'(m_ovf));
            check("unf", 32'(bus.out_underflow), 32'(m_unf));
        end
    end

    task automatic drive(input bit rst, input bit psh,
                         input bit pp, input logic [PW-1:0] pc,
                         input logic [FW-1:0] fl, input bit clr);
        @(negedge clk);
        reset            = rst;
        bus.in_push_en   = psh;
        bus.in_pop_en    = pp;
        bus.in_pc        = pc;
        bus.in_flags     = fl;
        bus.in_clear_err = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 0, '0, '0, 0);
    endtask

    initial begin
        reset = 1'b1;
        bus.in_push_en = 0; bus.in_pop_en = 0;
        bus.in_pc = '0; bus.in_flags = '0;
        bus.in_clear_err = 0;
        drive(1, 0, 0, '0, '0, 0);
        chk_en = 1'b1;
        check("rst_depth", 32'(bus.out_depth), 0);
        check("rst_empty", 32'(bus.out_empty), 1);
        check("rst_pc", 32'(bus.out_pc), 0);

        // 1: single push/pop
        drive(0, 1, 0, 9'h1E1, 4'b1001, 0);
        drive(0, 0, 1, '0, '0, 0);
        check("t1_pc", 32'(bus.out_pc), 32'h1E1);
        check("t1_fl", 32'(bus.out_flags), 32'b1001);
        check("t1_valid", 32'(bus.out_pop_valid), 1);
        check("t1_empty", 32'(bus.out_empty), 1);
        idle();
        check("t1_pulse", 32'(bus.out_pop_valid), 0);

        // 2: fill, overflow, LIFO drain
        for (int i = 1; i <= 8; i++)
            drive(0, 1, 0, PW'(i), FW'(i), 0);
        check("t2_full", 32'(bus.out_full), 1);
        drive(0, 1, 0, 9'h0FF, 4'hF, 0);
        check("t2_ovf", 32'(bus.out_overflow), 1);
        check("t2_depth", 32'(bus.out_depth), 8);
        for (int i = 8; i >= 1; i--) begin
            drive(0, 0, 1, '0, '0, 0);
            check("t2_lifo", 32'(bus.out_pc), 32'(i));
        end

        // 3: underflow and clear
        drive(0, 0, 1, '0, '0, 0);
        check("t3_unf", 32'(bus.out_underflow), 1);
        check("t3_pc", 32'(bus.out_pc), 1);
        check("t3_valid", 32'(bus.out_pop_valid), 0);
        drive(0, 0, 0, '0, '0, 1);
        check("t3_clr", 32'(bus.out_underflow), 0);

        // 4: tail call
        drive(0, 1, 0, 9'h010, 4'h1, 0);
        drive(0, 1, 0, 9'h020, 4'h2, 0);
        drive(0, 1, 1, 9'h030, 4'h3, 0);
        check("t4_pc", 32'(bus.out_pc), 32'h020);
        check("t4_depth", 32'(bus.out_depth), 2);
        drive(0, 0, 1, '0, '0, 0);
        check("t4_pop1", 32'(bus.out_pc), 32'h030);
        drive(0, 0, 1, '0, '0, 0);
        check("t4_pop2", 32'(bus.out_pc), 32'h010);

        // 5: reset mid-sequence
        for (int i = 0; i < 3; i++)
            drive(0, 1, 0, PW'(i + 5), '0, 0);
        drive(1, 0, 0, '0, '0, 0);
        check("t5_depth", 32'(bus.out_depth), 0);
        check("t5_empty", 32'(bus.out_empty), 1);
        check("t5_pc", 32'(bus.out_pc), 0);
        drive(0, 0, 1, '0, '0, 0);
        check("t5_unf", 32'(bus.out_underflow), 1);

        // 6: push+pop on empty acts as push
        drive(0, 0, 0, '0, '0, 1);
        drive(0, 1, 1, 9'h055, 4'h5, 0);
        check("t6_depth", 32'(bus.out_depth), 1);
        check("t6_unf", 32'(bus.out_underflow), 0);
        check("t6_valid", 32'(bus.out_pop_valid), 0);
        drive(0, 0, 1, '0, '0, 0);
        check("t6_pc", 32'(bus.out_pc), 32'h055);

        // random phases biased toward full, empty and balanced
        for (int i = 0; i < 3000; i++) begin
            int mode, pp, qp;
            mode = (i / 64) % 3;
            pp = (mode == 0) ? 70 : (mode == 1) ? 30 : 50;
            qp = 100 - pp;
            drive($urandom_range(0, 299) == 0,
                  $urandom_range(0, 99) < pp,
                  $urandom_range(0, 99) < qp,
                  PW'($urandom), FW'($urandom),
                  $urandom_range(0, 19) == 0);
        end
        idle();
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end
endmodule
